// File: rtl/wb_serial_arbiter.sv
// ---------------------------------------------------------------------------
// wb_serial_arbiter
// Two-master Wishbone arbiter in front of the serial transmitter's single
// slave port. M0 is the host/CPU side, M1 the test sequencer / DMA side.
// Ownership is granted round-robin when both request together and is then
// held for the whole CYC. A watchdog aborts a strobe that waits too long
// for ACK/ERR, answering the owner with ERR.
//
// Ports
//   CLK_I, RST_I             clock (rising edge), async active-low reset
//   M0_* / M1_*              master-side Wishbone ports (CYC/STB/WE/ADR/DAT in,
//                            ACK/ERR/DAT out)
//   S_*                      slave-side Wishbone port towards the transmitter
//   GNT_O                    one-hot current owner, 00 when the bus is free
//   TIMEOUT_O                one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_serial_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic          M0_CYC_I,
    input  logic          M0_STB_I,
    input  logic          M0_WE_I,
    input  logic [AW-1:0] M0_ADR_I,
    input  logic [DW-1:0] M0_DAT_I,
    output logic          M0_ACK_O,
    output logic          M0_ERR_O,
    output logic [DW-1:0] M0_DAT_O,
    input  logic          M1_CYC_I,
    input  logic          M1_STB_I,
    input  logic          M1_WE_I,
    input  logic [AW-1:0] M1_ADR_I,
    input  logic [DW-1:0] M1_DAT_I,
    output logic          M1_ACK_O,
    output logic          M1_ERR_O,
    output logic [DW-1:0] M1_DAT_O,
    output logic          S_CYC_O,
    output logic          S_STB_O,
    output logic          S_WE_O,
    output logic [AW-1:0] S_ADR_O,
    output logic [DW-1:0] S_DAT_O,
    input  logic          S_ACK_I,
    input  logic          S_ERR_I,
    input  logic [DW-1:0] S_DAT_I,
    output logic [1:0]    GNT_O,
    output logic          TIMEOUT_O
);

    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCW-1:0] WLIMIT = WCW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           lastOwner_q, lastOwner_d;    // 0 = M0, 1 = M1
    logic           abortOwner_q, abortOwner_d;  // owner that was aborted
    logic [WCW-1:0] wcnt_q, wcnt_d;

    logic          owning;
    logic          curOwner;
    logic          ownCyc;
    logic          ownStb;
    logic          ownWe;
    logic [AW-1:0] ownAdr;
    logic [DW-1:0] ownDat;
    logic          slvDone;
    logic          fire;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q      <= IDLE;
            lastOwner_q  <= 1'b1;
            abortOwner_q <= 1'b0;
            wcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            lastOwner_q  <= lastOwner_d;
            abortOwner_q <= abortOwner_d;
            wcnt_q       <= wcnt_d;
        end
    end

    // Select the current owner's request. In ABORT the owner is remembered
    // separately so its CYC can still be watched for the exit condition.
    always_comb begin
        owning   = (state_q == OWN0) || (state_q == OWN1);
        curOwner = (state_q == OWN1) ? 1'b1 :
                   (state_q == OWN0) ? 1'b0 : abortOwner_q;
        ownCyc   = curOwner ? M1_CYC_I : M0_CYC_I;
        ownStb   = curOwner ? M1_STB_I : M0_STB_I;
        ownWe    = curOwner ? M1_WE_I  : M0_WE_I;
        ownAdr   = curOwner ? M1_ADR_I : M0_ADR_I;
        ownDat   = curOwner ? M1_DAT_I : M0_DAT_I;
        slvDone  = S_ACK_I | S_ERR_I;
        // A slave response in the firing cycle wins over the timeout.
        fire     = owning && ownCyc && ownStb && !slvDone && (wcnt_q == WLIMIT);
    end

    // Next-state logic: arbitration in IDLE, hold while owner CYC stays high,
    // abort on watchdog, and round-robin bookkeeping when ownership ends.
    always_comb begin
        state_d      = state_q;
        lastOwner_d  = lastOwner_q;
        abortOwner_d = abortOwner_q;
        unique case (state_q)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) begin
                    state_d = lastOwner_q ? OWN0 : OWN1;
                end else if (M0_CYC_I) begin
                    state_d = OWN0;
                end else if (M1_CYC_I) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!ownCyc) begin
                    state_d     = IDLE;
                    lastOwner_d = curOwner;
                end else if (fire) begin
                    state_d      = ABORT;
                    abortOwner_d = curOwner;
                end
            end
            ABORT: begin
                if (!ownCyc) begin
                    state_d     = IDLE;
                    lastOwner_d = abortOwner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog counter: counts strobe cycles without a slave response. It can
    // never pass WLIMIT because reaching it either fires or gets answered.
    always_comb begin
        wcnt_d = '0;
        if (owning && ownCyc && ownStb && !slvDone && !fire) begin
            wcnt_d = wcnt_q + WCW'(1);
        end
    end

    // Output muxing: the owner is wired straight through to the slave; the
    // non-owner never sees ACK/ERR. Read data goes to both masters.
    always_comb begin
        S_CYC_O   = 1'b0;
        S_STB_O   = 1'b0;
        S_WE_O    = 1'b0;
        S_ADR_O   = '0;
        S_DAT_O   = '0;
        M0_ACK_O  = 1'b0;
        M0_ERR_O  = 1'b0;
        M1_ACK_O  = 1'b0;
        M1_ERR_O  = 1'b0;
        TIMEOUT_O = fire;
        M0_DAT_O  = S_DAT_I;
        M1_DAT_O  = S_DAT_I;
        GNT_O     = 2'b00;
        if (owning) begin
            S_CYC_O = ownCyc;
            S_STB_O = ownStb;
            S_WE_O  = ownWe;
            S_ADR_O = ownAdr;
            S_DAT_O = ownDat;
            if (curOwner) begin
                M1_ACK_O = S_ACK_I;
                M1_ERR_O = S_ERR_I | fire;
            end else begin
                M0_ACK_O = S_ACK_I;
                M0_ERR_O = S_ERR_I | fire;
            end
        end
        if (state_q != IDLE) begin
            GNT_O = curOwner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_wb_serial_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_serial_arbiter
// Directed scenarios followed by random traffic, all compared every cycle
// against a transaction-level model of the arbiter kept in this bench.
// ---------------------------------------------------------------------------
module tb_wb_serial_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rstN;
    logic [1:0]    mCyc, mStb, mWe;
    logic [AW-1:0] mAdr [2];
    logic [DW-1:0] mDat [2];
    logic          sAck, sErr;
    logic [DW-1:0] sDatIn;

    logic          m0Ack, m0Err, m1Ack, m1Err, sCyc, sStb, sWe, tmo;
    logic [DW-1:0] m0DatO, m1DatO, sDatO;
    logic [AW-1:0] sAdr;
    logic [1:0]    gnt;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: who owns the bus, whether it was aborted, who owned
    // last, and how many strobe cycles the current access has waited.
    int mOwner;
    bit mAborted;
    int mLast;
    int mWait;

    wb_serial_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
        .CLK_I(clk), .RST_I(rstN),
        .M0_CYC_I(mCyc[0]), .M0_STB_I(mStb[0]), .M0_WE_I(mWe[0]),
        .M0_ADR_I(mAdr[0]), .M0_DAT_I(mDat[0]),
        .M0_ACK_O(m0Ack), .M0_ERR_O(m0Err), .M0_DAT_O(m0DatO),
        .M1_CYC_I(mCyc[1]), .M1_STB_I(mStb[1]), .M1_WE_I(mWe[1]),
        .M1_ADR_I(mAdr[1]), .M1_DAT_I(mDat[1]),
        .M1_ACK_O(m1Ack), .M1_ERR_O(m1Err), .M1_DAT_O(m1DatO),
        .S_CYC_O(sCyc), .S_STB_O(sStb), .S_WE_O(sWe),
        .S_ADR_O(sAdr), .S_DAT_O(sDatO),
        .S_ACK_I(sAck), .S_ERR_I(sErr), .S_DAT_I(sDatIn),
        .GNT_O(gnt), .TIMEOUT_O(tmo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit modelFire();
        if (mOwner < 0 || mAborted) return 1'b0;
        return mCyc[mOwner] && mStb[mOwner] && !sAck && !sErr && (mWait == TMO - 1);
    endfunction

    task automatic modelReset();
        mOwner   = -1;
        mAborted = 1'b0;
        mLast    = 1;
        mWait    = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic modelUpdate();
        bit f;
        f = modelFire();
        if (mOwner < 0) begin
            if (mCyc == 2'b11)     mOwner = 1 - mLast;
            else if (mCyc[0])      mOwner = 0;
            else if (mCyc[1])      mOwner = 1;
            mWait = 0;
        end else if (!mCyc[mOwner]) begin
            mLast    = mOwner;
            mOwner   = -1;
            mAborted = 1'b0;
            mWait    = 0;
        end else if (!mAborted) begin
            if (f) begin
                mAborted = 1'b1;
                mWait    = 0;
            end else if (mStb[mOwner] && !sAck && !sErr) begin
                mWait++;
            end else begin
                mWait = 0;
            end
        end
    endtask

    // Compare every output with the model, a little after the inputs change.
    task automatic checkOutput(input string tag);
        logic [1:0]    eGnt, eAck, eErr;
        logic [2:0]    eBus;
        logic [AW-1:0] eAdr;
        logic [DW-1:0] eDat;
        bit            f;
        #1;
        f    = modelFire();
        eGnt = (mOwner < 0) ? 2'b00 : 2'(1 << mOwner);
        eBus = '0; eAdr = '0; eDat = '0; eAck = '0; eErr = '0;
        if (mOwner >= 0 && !mAborted) begin
            eBus = {mCyc[mOwner], mStb[mOwner], mWe[mOwner]};
            eAdr = mAdr[mOwner];
            eDat = mDat[mOwner];
            eAck[mOwner] = sAck;
            eErr[mOwner] = sErr | f;
        end
        cmp({tag, ".gnt"}, 64'(gnt), 64'(eGnt));
        cmp({tag, ".sbus"}, 64'({sCyc, sStb, sWe}), 64'(eBus));
        cmp({tag, ".sadr"}, 64'(sAdr), 64'(eAdr));
        cmp({tag, ".sdat"}, 64'(sDatO), 64'(eDat));
        cmp({tag, ".ack"}, 64'({m1Ack, m0Ack}), 64'(eAck));
        cmp({tag, ".err"}, 64'({m1Err, m0Err}), 64'(eErr));
        cmp({tag, ".tmo"}, 64'(tmo), 64'(f));
        cmp({tag, ".rdat"}, 64'({m1DatO, m0DatO}), 64'({sDatIn, sDatIn}));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rstN) modelUpdate();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input string tag);
        checkOutput(tag);
        advance();
    endtask

    task automatic setM(input int m, input logic c, input logic s, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        mCyc[m] = c; mStb[m] = s; mWe[m] = w; mAdr[m] = a; mDat[m] = d;
    endtask

    initial begin
        rstN = 1'b0;
        modelReset();
        setM(0, 1'b1, 1'b0, 1'b0, '0, '0);
        setM(1, 1'b0, 1'b0, 1'b0, '0, '0);
        sAck = 1'b0; sErr = 1'b0; sDatIn = 32'h1234_5678;
        @(negedge clk);

        // Reset holds everything idle even with a request pending.
        checkOutput("rst");
        cmp("rst.gntZero", 64'(gnt), 64'd0);
        cmp("rst.scycZero", 64'(sCyc), 64'd0);
        advance();
        rstN = 1'b1;
        applyStimulus("rel");
        checkOutput("rel.own");
        cmp("rel.gnt01", 64'(gnt), 64'd1);
        advance();

        // Single write from M0, slave acknowledges in the second cycle.
        setM(0, 1'b1, 1'b1, 1'b1, 32'h0000_0004, 32'h0000_00A5);
        applyStimulus("wr.wait");
        sAck = 1'b1;
        checkOutput("wr.ack");
        cmp("wr.adr", 64'(sAdr), 64'h4);
        cmp("wr.dat", 64'(sDatO), 64'hA5);
        cmp("wr.m0ack", 64'(m0Ack), 64'd1);
        cmp("wr.m1ack", 64'(m1Ack), 64'd0);
        advance();
        sAck = 1'b0;
        setM(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus("wr.end");

        // Tie after reset: M0 first, one idle cycle, then M1, then M0 again.
        rstN = 1'b0;
        modelReset();
        applyStimulus("tie.rst");
        rstN = 1'b1;
        mCyc = 2'b11;
        applyStimulus("tie.req");
        checkOutput("tie.first");
        cmp("tie.gnt01", 64'(gnt), 64'd1);
        advance();
        mCyc[0] = 1'b0;
        applyStimulus("tie.drop0");
        checkOutput("tie.gap");
        cmp("tie.gap00", 64'(gnt), 64'd0);
        advance();
        checkOutput("tie.second");
        cmp("tie.gnt10", 64'(gnt), 64'd2);
        advance();
        mCyc = 2'b00;
        applyStimulus("tie.drop1");
        mCyc = 2'b11;
        applyStimulus("tie.req2");
        checkOutput("tie.third");
        cmp("tie.gnt01b", 64'(gnt), 64'd1);
        advance();

        // Hold: M1 runs a 5-beat burst while M0 keeps requesting.
        mCyc = 2'b10;
        applyStimulus("hold.swap");
        applyStimulus("hold.grant");
        setM(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        setM(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
        sAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mDat[1] = $urandom;
            checkOutput("hold.beat");
            cmp("hold.gnt10", 64'(gnt), 64'd2);
            cmp("hold.m0ack", 64'(m0Ack), 64'd0);
            advance();
        end
        sAck = 1'b0;
        setM(1, 1'b0, 1'b0, 1'b0, '0, '0);
        mStb[0] = 1'b0;
        applyStimulus("hold.rel");
        applyStimulus("hold.idle");

        // Timeout: M0 strobes, slave never answers.
        mStb[0] = 1'b1;
        for (int i = 1; i <= TMO; i++) begin
            checkOutput("tmo.wait");
            cmp("tmo.pulse", 64'(tmo), 64'(i == TMO));
            cmp("tmo.m0err", 64'(m0Err), 64'(i == TMO));
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("tmo.abort");
            cmp("tmo.scyc", 64'(sCyc), 64'd0);
            advance();
        end
        setM(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus("tmo.exit");

        // ACK lands in the very cycle the watchdog would fire.
        mCyc[0] = 1'b1;
        applyStimulus("edge.req");
        applyStimulus("edge.own");
        mStb[0] = 1'b1;
        for (int i = 1; i < TMO; i++) applyStimulus("edge.wait");
        sAck = 1'b1;
        checkOutput("edge.ack");
        cmp("edge.tmo", 64'(tmo), 64'd0);
        cmp("edge.err", 64'(m0Err), 64'd0);
        cmp("edge.m0ack", 64'(m0Ack), 64'd1);
        advance();
        sAck = 1'b0;
        setM(0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus("edge.end");

        // Random traffic with occasional async resets.
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 5) == 0) mCyc[m] = ~mCyc[m];
                mStb[m] = mCyc[m] && ($urandom_range(0, 9) != 0);
                mWe[m]  = 1'($urandom);
                mAdr[m] = $urandom;
                mDat[m] = $urandom;
            end
            sAck   = ($urandom_range(0, 5) == 0);
            sErr   = ($urandom_range(0, 15) == 0);
            sDatIn = $urandom;
            if (rstN && $urandom_range(0, 149) == 0) begin
                rstN = 1'b0;
                modelReset();
            end else begin
                rstN = 1'b1;
            end
            applyStimulus("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
